// File: rtl/param_serializer.sv
// Frame serializer: shadow bank of NWORDS parameter words, snapshotted on start and
// shifted out MSB first after an 8-bit training pattern, with a mid-bit rising sclk.
module param_serializer #(
   parameter int         CLKDIV = 8,
   parameter int         WIDTH  = 35,
   parameter int         NWORDS = 12,
   parameter logic [7:0] TP     = 8'b10000111
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic signed [WIDTH-1:0] word_in,
   input  logic [3:0]              word_addr_in,
   input  logic                    word_we_in,
   input  logic                    start_in,
   output logic                    serial_out,
   output logic                    sclk_out,
   output logic                    frame_out,
   output logic                    busy_out,
   output logic                    done_out
);

   localparam int DW  = $clog2(CLKDIV);
   localparam int WBW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int BW  = (WBW > 3) ? WBW : 3;

   localparam logic [DW-1:0] DIV_LAST  = DW'(CLKDIV - 1);
   localparam logic [DW-1:0] DIV_HALF  = DW'(CLKDIV / 2);
   localparam logic [BW-1:0] TP_LAST   = BW'(7);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
   localparam logic [3:0]    WORD_LAST = 4'(NWORDS - 1);
   localparam logic [7:0]    TP_BITS   = TP;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_TPS   = 2'd1;
   localparam logic [1:0] S_WORDS = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [WIDTH-1:0] shadow_bank [NWORDS];
   logic [WIDTH-1:0] tx_bank     [NWORDS];
   logic [NWORDS-1:0] wr_hit;

   logic [1:0]    state, state_next;
   logic [DW-1:0] div_cnt, div_next;
   logic [BW-1:0] bit_cnt, bit_next;
   logic [3:0]    word_idx, word_next;
   logic          load;

   logic           serial_next, sclk_next, frame_next, busy_next, done_next;
   logic [WBW-1:0] bit_sel;
   logic [2:0]     tp_sel;

   // Addresses at or above NWORDS match no entry and are dropped.
   genvar gi;
   generate
      for (gi = 0; gi < NWORDS; gi++) begin : g_hit
         assign wr_hit[gi] = word_we_in && (word_addr_in == 4'(gi));
      end
   endgenerate

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < NWORDS; i++) begin
            shadow_bank[i] <= '0;
            tx_bank[i]     <= '0;
         end
      end else begin
         for (int i = 0; i < NWORDS; i++) begin
            if (wr_hit[i])
               shadow_bank[i] <= word_in;
            // A write coinciding with start goes straight into the snapshot too.
            if (load)
               tx_bank[i] <= wr_hit[i] ? word_in : shadow_bank[i];
         end
      end
   end

   always_comb begin
      state_next = state;
      div_next   = div_cnt;
      bit_next   = bit_cnt;
      word_next  = word_idx;
      load       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_in) begin
               state_next = S_TPS;
               div_next   = '0;
               bit_next   = '0;
               word_next  = '0;
               load       = 1'b1;
            end
         end
         S_TPS: begin
            if (div_cnt == DIV_LAST) begin
               div_next = '0;
               if (bit_cnt == TP_LAST) begin
                  state_next = S_WORDS;
                  bit_next   = '0;
                  word_next  = '0;
               end else begin
                  bit_next = bit_cnt + 1'b1;
               end
            end else begin
               div_next = div_cnt + 1'b1;
            end
         end
         S_WORDS: begin
            if (div_cnt == DIV_LAST) begin
               div_next = '0;
               if (bit_cnt == BIT_LAST) begin
                  bit_next = '0;
                  if (word_idx == WORD_LAST)
                     state_next = S_DONE;
                  else
                     word_next = word_idx + 1'b1;
               end else begin
                  bit_next = bit_cnt + 1'b1;
               end
            end else begin
               div_next = div_cnt + 1'b1;
            end
         end
         default: begin
            state_next = S_IDLE;
            div_next   = '0;
            bit_next   = '0;
            word_next  = '0;
         end
      endcase
   end

   // Outputs are computed from the next state so the registered pins line up with it.
   always_comb begin
      bit_sel     = WBW'(BIT_LAST - bit_next);
      tp_sel      = ~bit_next[2:0];
      serial_next = 1'b0;
      case (state_next)
         S_TPS:   serial_next = TP_BITS[tp_sel];
         S_WORDS: serial_next = tx_bank[word_next][bit_sel];
         default: serial_next = 1'b0;
      endcase
      frame_next = (state_next == S_TPS) || (state_next == S_WORDS);
      sclk_next  = frame_next && (div_next >= DIV_HALF);
      busy_next  = frame_next || (state_next == S_DONE);
      done_next  = (state_next == S_DONE);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state      <= S_IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         word_idx   <= '0;
         serial_out <= 1'b0;
         sclk_out   <= 1'b0;
         frame_out  <= 1'b0;
         busy_out   <= 1'b0;
         done_out   <= 1'b0;
      end else begin
         state      <= state_next;
         div_cnt    <= div_next;
         bit_cnt    <= bit_next;
         word_idx   <= word_next;
         serial_out <= serial_next;
         sclk_out   <= sclk_next;
         frame_out  <= frame_next;
         busy_out   <= busy_next;
         done_out   <= done_next;
      end
   end

endmodule

// File: tb/tb_param_serializer.sv
// Scoreboard bench for param_serializer: each accepted start queues the full per-cycle
// output waveform of its frame, and every falling edge compares the pins against it.
module tb_param_serializer;

   localparam int         CLKDIV = 8;
   localparam int         WIDTH  = 35;
   localparam int         NWORDS = 12;
   localparam logic [7:0] TP     = 8'b10000111;
   localparam int         NBITS  = 8 + NWORDS * WIDTH;
   localparam int         FRAME_EDGES = NBITS * CLKDIV + 1;

   logic                    clk;
   logic                    rst_n;
   logic signed [WIDTH-1:0] word_in;
   logic [3:0]              word_addr;
   logic                    word_we;
   logic                    start;
   logic                    serial, sclk, frame, busy, done;

   typedef struct {
      int unsigned at_edge;
      logic [4:0]  v;
   } exp_t;

   exp_t             exp_q[$];
   int unsigned      edge_cnt = 0;
   int unsigned      busy_until = 0;
   int               n_tests = 0;
   int               n_fail = 0;
   logic [WIDTH-1:0] shadow_m [NWORDS];

   param_serializer #(.CLKDIV(CLKDIV), .WIDTH(WIDTH), .NWORDS(NWORDS), .TP(TP)) dut (
      .clk_in      (clk),
      .rst_n_in    (rst_n),
      .word_in     (word_in),
      .word_addr_in(word_addr),
      .word_we_in  (word_we),
      .start_in    (start),
      .serial_out  (serial),
      .sclk_out    (sclk),
      .frame_out   (frame),
      .busy_out    (busy),
      .done_out    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Expected {serial, sclk, frame, busy, done} for every edge of a frame started at edge s.
   task automatic push_frame(input int unsigned s);
      exp_t e;
      logic b;
      int   k, ph, w, bi;
      for (int c = 0; c < NBITS * CLKDIV; c++) begin
         k  = c / CLKDIV;
         ph = c % CLKDIV;
         if (k < 8) begin
            b = TP[7 - k];
         end else begin
            w  = (k - 8) / WIDTH;
            bi = WIDTH - 1 - ((k - 8) % WIDTH);
            b  = shadow_m[w][bi];
         end
         e.at_edge = s + c;
         e.v       = {b, (ph >= CLKDIV / 2), 1'b1, 1'b1, 1'b0};
         exp_q.push_back(e);
      end
      e.at_edge = s + NBITS * CLKDIV;
      e.v       = 5'b00011;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic st, input logic we, input logic [3:0] a, input logic [WIDTH-1:0] d);
      int unsigned s;
      start     = st;
      word_we   = we;
      word_addr = a;
      word_in   = d;
      s = edge_cnt + 1;
      if (we && a < NWORDS) shadow_m[a] = d;
      if (st && s > busy_until) begin
         push_frame(s);
         busy_until = s + NBITS * CLKDIV + 1;
      end
      @(negedge clk); #1;
      start   = 1'b0;
      word_we = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk); #1;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < FRAME_EDGES + 100 && exp_q.size() != 0; i++) begin
         @(negedge clk); #1;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      logic [4:0] want;
      want = 5'b0;
      if (exp_q.size() != 0 && exp_q[0].at_edge == edge_cnt)
         want = exp_q.pop_front().v;
      check($sformatf("outs e%0d", edge_cnt), {serial, sclk, frame, busy, done}, want);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      word_we   = 1'b0;
      word_addr = 4'd0;
      word_in   = '0;
      for (int i = 0; i < NWORDS; i++) shadow_m[i] = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outs", {serial, sclk, frame, busy, done}, 5'b0);
      rst_n = 1'b1;
      idle(2);

      // Basic frame: word0 = 0x4_0000_0001, rest zero; done after 3425 cycles.
      drive(1'b0, 1'b1, 4'd0, 35'h4_0000_0001);
      drive(1'b1, 1'b0, 4'd0, '0);
      drain();

      // Write during TPS must not disturb the running frame; start at cycle ~100 ignored.
      idle(1);
      drive(1'b1, 1'b0, 4'd0, '0);
      idle(18);
      drive(1'b0, 1'b1, 4'd0, '1);
      idle(78);
      drive(1'b1, 1'b0, 4'd0, '0);
      for (int i = 1; i < NWORDS; i++)
         drive(1'b0, 1'b1, 4'(i), WIDTH'({$urandom(), $urandom()}));
      drain();

      // Back-to-back start one cycle after DONE, with a write on the start edge.
      idle(1);
      drive(1'b1, 1'b1, 4'd5, 35'h5_A5A5_1234);
      drain();

      // Out-of-range addresses leave the bank untouched.
      drive(1'b0, 1'b1, 4'd12, '1);
      drive(1'b0, 1'b1, 4'd15, 35'h1_2345_6789);
      drive(1'b1, 1'b0, 4'd0, '0);
      drain();

      // Reset during WORDS: outputs drop at once, no done, banks cleared.
      idle(1);
      drive(1'b1, 1'b0, 4'd0, '0);
      idle(300);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async", {serial, sclk, frame, busy, done}, 5'b0);
      exp_q.delete();
      busy_until = 0;
      for (int i = 0; i < NWORDS; i++) shadow_m[i] = '0;
      idle(3);
      rst_n = 1'b1;
      idle(2);

      // First frame after reset is TP followed by all zeros.
      drive(1'b1, 1'b0, 4'd0, '0);
      drain();
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
